p405s_exe_gpr_scb: RTL and testbench
====================================

Name: p405s_exe_gpr_scb

Overview:
- Parametrised successor to the execute-stage GPR file: DEPTH x DW registers, NUM_RD combinational read ports, two write ports (L = load return, R = ALU result).
- Same-cycle write-through bypass on every read port.
- Adds an asynchronous clear of the whole file and a per-register load scoreboard. The scoreboard flags reads of registers whose load data has not yet returned, so issue logic can stall.
- Sits between decode/issue and the execute datapath.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; must be a power of two, 2..64.
- AW, 5, address width; must equal log2(DEPTH).
- NUM_RD, 3, number of read ports, 1..4.
- RST_VAL, 0, value loaded into every register on reset.

Ports:
- SysClk  in  1  rising-edge clock.
- SysReset  in  1  asynchronous, active-high reset.
- RdAddr  in  NUM_RD*AW  binary read addresses; port i occupies bits [i*AW +: AW].
- RdData  out  NUM_RD*DW  read data; port i occupies bits [i*DW +: DW].
- RdBusy  out  NUM_RD  per-port flag: the addressed register has an outstanding load.
- LpAddr  in  AW  L write address.
- LpWE  in  1  L write enable.
- lPort  in  DW  L write data.
- RpAddr  in  AW  R write address.
- RpWE  in  1  R write enable.
- rPort  in  DW  R write data.
- IssueLd  in  1  a load targeting IssueAddr issues this cycle.
- IssueAddr  in  AW  load target register.
- WrCollide  out  1  registered flag: previous cycle had LpWE & RpWE with LpAddr == RpAddr.
- BusyVec  out  DEPTH  current scoreboard bits; bit n corresponds to register n.

Behaviour:
- Reset (SysReset = 1, asynchronous, independent of SysClk):
  - all registers = RST_VAL, BusyVec = 0, WrCollide = 0.
  - RdData reflects RST_VAL combinationally; RdBusy = 0.
  - Reset overrides any write or issue in flight. After deassertion, the first capturing edge is the next SysClk rising edge.
- Writes, at the rising edge of SysClk:
  - LpWE writes lPort to reg[LpAddr]; RpWE writes rPort to reg[RpAddr].
  - Different addresses: both writes land.
  - Same address with both enables: the R write wins, the L data is dropped, and WrCollide = 1 on the following cycle for exactly one cycle.
- Reads, combinational, zero latency:
  - RdData[i] = rPort if RpWE & RdAddr[i] == RpAddr.
  - Otherwise lPort if LpWE & RdAddr[i] == LpAddr.
  - Otherwise reg[RdAddr[i]].
  - The R path has priority, matching the write-collision winner. Data captured downstream at the edge therefore equals the post-write register value.
  - Any number of read ports may address the same register.
- Scoreboard, busy[n], updated at the rising edge:
  - Set when IssueLd & IssueAddr == n.
  - Cleared when LpWE & LpAddr == n.
  - Set and clear on the same n in the same cycle: set wins (a new load replaces the returning one).
  - An R write does not change busy.
  - IssueLd while busy[IssueAddr] is already 1: busy stays 1, no error.
- RdBusy[i] = busy[RdAddr[i]] & ~(LpWE & LpAddr == RdAddr[i]).
  - The returning load is bypassed, so the register is not busy in its return cycle.
  - Same-cycle IssueLd does not affect RdBusy until the next cycle.
- Out-of-range addresses cannot occur, since DEPTH = 2^AW.
- No X propagation: every read path returns a defined value after reset.

Test Plan:
- Reset mid-write: R-write reg5 = 0xDEADBEEF is in flight while SysReset pulses 3 ns between edges -> reg5 = 0, BusyVec = 0, RdData = 0 immediately; the write is lost.
- Dual write, distinct addresses: L writes reg3 = 0x11111111 and R writes reg4 = 0x22222222 in the same cycle; next cycle read ports 0/1/2 = 3/4/3 -> 0x11111111 / 0x22222222 / 0x11111111; WrCollide = 0.
- Collision: L and R both target reg7 (0xAAAA0000, 0x5555FFFF) -> same-cycle bypass reads 0x5555FFFF; reg7 = 0x5555FFFF after the edge; WrCollide = 1 for exactly one cycle.
- Bypass: read port 2 addresses reg9 while LpWE writes 0x12345678 to reg9 -> RdData[2] = 0x12345678 in that cycle; the old value is never presented.
- Scoreboard lifecycle: IssueLd reg12 at cycle 0 -> BusyVec[12] = 1 and RdBusy = 1 on a reading port from cycle 1. LpWE reg12 at cycle 4 -> RdBusy = 0 in cycle 4; BusyVec[12] = 0 from cycle 5.
- Set/clear race plus parameter sweep: IssueLd reg12 and LpWE reg12 in the same cycle -> BusyVec[12] stays 1. Repeat all scenarios with DW = 64, DEPTH = 16, AW = 4, NUM_RD = 4.

Source files
------------

// File: rtl/p405s_exe_gpr_scb_if.sv
//==============================================================================
// Module   : p405s_exe_gpr_scb_if
// Purpose  : Issue-side bundle of the execute-stage GPR file: read ports,
//            L/R write ports, load-issue hook and scoreboard status.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface p405s_exe_gpr_scb_if #(
    parameter int DW     = 32,
    parameter int DEPTH  = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 3
);
    logic [NUM_RD*AW-1:0] RdAddr;
    logic [NUM_RD*DW-1:0] RdData;
    logic [NUM_RD-1:0]    RdBusy;
    logic [AW-1:0]        LpAddr;
    logic                 LpWE;
    logic [DW-1:0]        lPort;
    logic [AW-1:0]        RpAddr;
    logic                 RpWE;
    logic [DW-1:0]        rPort;
    logic                 IssueLd;
    logic [AW-1:0]        IssueAddr;
    logic                 WrCollide;
    logic [DEPTH-1:0]     BusyVec;

    modport master (
        output RdAddr, LpAddr, LpWE, lPort, RpAddr, RpWE, rPort, IssueLd, IssueAddr,
        input  RdData, RdBusy, WrCollide, BusyVec
    );

    modport slave (
        input  RdAddr, LpAddr, LpWE, lPort, RpAddr, RpWE, rPort, IssueLd, IssueAddr,
        output RdData, RdBusy, WrCollide, BusyVec
    );
endinterface

`default_nettype wire

// File: rtl/p405s_exe_gpr_scb.sv
//==============================================================================
// Module   : p405s_exe_gpr_scb
// Purpose  : Parametrised GPR file with two write ports, write-through read
//            bypass and a per-register outstanding-load scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module p405s_exe_gpr_scb #(
    parameter int            DW      = 32,
    parameter int            DEPTH   = 32,
    parameter int            AW      = 5,
    parameter int            NUM_RD  = 3,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic               SysClk,
    input  logic               SysReset,
    p405s_exe_gpr_scb_if.slave gpr
);

    if ((DEPTH != (1 << AW)) || (DEPTH < 2) || (DEPTH > 64) ||
        (NUM_RD < 1) || (NUM_RD > 4)) begin : g_bad_param
        $error("p405s_exe_gpr_scb: illegal DEPTH/AW/NUM_RD combination");
    end

    logic [DW-1:0]        w_regs [DEPTH];
    logic [DEPTH-1:0]     busy_q;
    logic [DEPTH-1:0]     busy_d;
    logic                 collide_q;
    logic                 collide_d;
    logic [NUM_RD*DW-1:0] w_rd_data;
    logic [NUM_RD-1:0]    w_rd_busy;

    //--------------------------------------------------------------------------
    // Register storage and scoreboard next-state, one slice per register
    //--------------------------------------------------------------------------
    for (genvar n = 0; n < DEPTH; n++) begin : g_reg
        localparam logic [AW-1:0] C_IDX = AW'(n);

        logic [DW-1:0] data_q;
        logic [DW-1:0] data_d;
        logic          w_lhit;
        logic          w_rhit;
        logic          w_set;

        assign w_lhit = gpr.LpWE    && (gpr.LpAddr    == C_IDX);
        assign w_rhit = gpr.RpWE    && (gpr.RpAddr    == C_IDX);
        assign w_set  = gpr.IssueLd && (gpr.IssueAddr == C_IDX);

        // R beats L on a shared target so the stored value matches the bypass
        always_comb begin
            data_d = data_q;
            if (w_rhit) begin
                data_d = gpr.rPort;
            end else if (w_lhit) begin
                data_d = gpr.lPort;
            end
        end

        always_ff @(posedge SysClk or posedge SysReset) begin
            if (SysReset) begin
                data_q <= RST_VAL;
            end else begin
                data_q <= data_d;
            end
        end

        assign w_regs[n] = data_q;
        // A newly issued load replaces the one returning in the same cycle
        assign busy_d[n] = w_set | (busy_q[n] & ~w_lhit);
    end

    assign collide_d = gpr.LpWE && gpr.RpWE && (gpr.LpAddr == gpr.RpAddr);

    always_ff @(posedge SysClk or posedge SysReset) begin
        if (SysReset) begin
            busy_q    <= '0;
            collide_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            collide_q <= collide_d;
        end
    end

    //--------------------------------------------------------------------------
    // Combinational read ports with write-through bypass
    //--------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_rbyp;
        logic          w_lbyp;

        assign w_addr = gpr.RdAddr[i*AW +: AW];
        // Bypass is suppressed during reset so reads show the cleared file
        assign w_rbyp = ~SysReset && gpr.RpWE && (gpr.RpAddr == w_addr);
        assign w_lbyp = ~SysReset && gpr.LpWE && (gpr.LpAddr == w_addr);

        assign w_rd_data[i*DW +: DW] = w_rbyp ? gpr.rPort :
                                       w_lbyp ? gpr.lPort : w_regs[w_addr];
        assign w_rd_busy[i]          = busy_q[w_addr] & ~w_lbyp;
    end

    assign gpr.RdData    = w_rd_data;
    assign gpr.RdBusy    = w_rd_busy;
    assign gpr.BusyVec   = busy_q;
    assign gpr.WrCollide = collide_q;

endmodule

`default_nettype wire

// File: tb/tb_p405s_exe_gpr_scb.sv
//==============================================================================
// Module   : tb_p405s_exe_gpr_scb
// Purpose  : Drives two configurations (32x32/3 ports, 16x64/4 ports) with the
//            same vector table and compares both against expected records.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_p405s_exe_gpr_scb;

    localparam int A_DW = 32, A_DEPTH = 32, A_AW = 5, A_NRD = 3;
    localparam int B_DW = 64, B_DEPTH = 16, B_AW = 4, B_NRD = 4;

    logic SysClk = 1'b0;
    logic SysReset;

    always #5 SysClk = ~SysClk;

    p405s_exe_gpr_scb_if #(.DW(A_DW), .DEPTH(A_DEPTH), .AW(A_AW), .NUM_RD(A_NRD)) ifa ();
    p405s_exe_gpr_scb_if #(.DW(B_DW), .DEPTH(B_DEPTH), .AW(B_AW), .NUM_RD(B_NRD)) ifb ();

    p405s_exe_gpr_scb #(
        .DW(A_DW), .DEPTH(A_DEPTH), .AW(A_AW), .NUM_RD(A_NRD), .RST_VAL(32'h0)
    ) dut_a (
        .SysClk   (SysClk),
        .SysReset (SysReset),
        .gpr      (ifa)
    );

    p405s_exe_gpr_scb #(
        .DW(B_DW), .DEPTH(B_DEPTH), .AW(B_AW), .NUM_RD(B_NRD), .RST_VAL(64'h0)
    ) dut_b (
        .SysClk   (SysClk),
        .SysReset (SysReset),
        .gpr      (ifb)
    );

    // ra/erd pack port 3 in the top nibble/word down to port 0 in the bottom
    typedef struct {
        logic [15:0]  ra;
        logic         lwe;
        logic [3:0]   la;
        logic [31:0]  ld;
        logic         rwe;
        logic [3:0]   rad;
        logic [31:0]  rd;
        logic         iss;
        logic [3:0]   ia;
        logic [127:0] erd;
        logic [3:0]   ebsy;
        logic [15:0]  ebv;
        logic         ecol;
    } vec_t;

    vec_t vecs [20];
    vec_t exp_q [$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic [15:0] ra,
                                input logic lwe, input logic [3:0] la, input logic [31:0] ld,
                                input logic rwe, input logic [3:0] rad, input logic [31:0] rd,
                                input logic iss, input logic [3:0] ia,
                                input logic [127:0] erd, input logic [3:0] ebsy,
                                input logic [15:0] ebv, input logic ecol);
        vec_t v;
        v.ra = ra; v.lwe = lwe; v.la = la; v.ld = ld;
        v.rwe = rwe; v.rad = rad; v.rd = rd; v.iss = iss; v.ia = ia;
        v.erd = erd; v.ebsy = ebsy; v.ebv = ebv; v.ecol = ecol;
        return v;
    endfunction

    // Wide configuration carries a half-swapped copy so both halves are exercised
    function automatic logic [63:0] w64(input logic [31:0] d);
        return {d[15:0], d[31:16], d};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        for (int i = 0; i < A_NRD; i++) ifa.RdAddr[i*A_AW +: A_AW] = {1'b0, v.ra[i*4 +: 4]};
        for (int i = 0; i < B_NRD; i++) ifb.RdAddr[i*B_AW +: B_AW] = v.ra[i*4 +: 4];
        ifa.LpWE = v.lwe; ifa.LpAddr = {1'b0, v.la};  ifa.lPort = v.ld;
        ifa.RpWE = v.rwe; ifa.RpAddr = {1'b0, v.rad}; ifa.rPort = v.rd;
        ifa.IssueLd = v.iss; ifa.IssueAddr = {1'b0, v.ia};
        ifb.LpWE = v.lwe; ifb.LpAddr = v.la;  ifb.lPort = w64(v.ld);
        ifb.RpWE = v.rwe; ifb.RpAddr = v.rad; ifb.rPort = w64(v.rd);
        ifb.IssueLd = v.iss; ifb.IssueAddr = v.ia;
    endtask

    task automatic check_outputs(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got empty expectation queue want a record", tag);
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < A_NRD; i++) begin
            chk($sformatf("%s A.rd%0d", tag, i), {32'h0, ifa.RdData[i*A_DW +: A_DW]},
                {32'h0, e.erd[i*32 +: 32]});
            chk($sformatf("%s A.busy%0d", tag, i), {63'h0, ifa.RdBusy[i]}, {63'h0, e.ebsy[i]});
        end
        for (int i = 0; i < B_NRD; i++) begin
            chk($sformatf("%s B.rd%0d", tag, i), ifb.RdData[i*B_DW +: B_DW], w64(e.erd[i*32 +: 32]));
            chk($sformatf("%s B.busy%0d", tag, i), {63'h0, ifb.RdBusy[i]}, {63'h0, e.ebsy[i]});
        end
        chk({tag, " A.busyvec"}, {32'h0, ifa.BusyVec}, {48'h0, e.ebv});
        chk({tag, " B.busyvec"}, {48'h0, ifb.BusyVec}, {48'h0, e.ebv});
        chk({tag, " A.collide"}, {63'h0, ifa.WrCollide}, {63'h0, e.ecol});
        chk({tag, " B.collide"}, {63'h0, ifb.WrCollide}, {63'h0, e.ecol});
    endtask

    initial begin
        // Reset state
        vecs[0]  = mk(16'h3210, 0, 0, 0, 0, 0, 0, 0, 0, 128'h0, 4'h0, 16'h0, 0);
        // Dual write to distinct registers, then read back
        vecs[1]  = mk(16'h4343, 1, 3, 32'h11111111, 1, 4, 32'h22222222, 0, 0,
                      {32'h22222222, 32'h11111111, 32'h22222222, 32'h11111111}, 4'h0, 16'h0, 0);
        vecs[2]  = mk(16'h4343, 0, 0, 0, 0, 0, 0, 0, 0,
                      {32'h22222222, 32'h11111111, 32'h22222222, 32'h11111111}, 4'h0, 16'h0, 0);
        // Collision on reg7: R wins, collide flag for one cycle
        vecs[3]  = mk(16'h7377, 1, 7, 32'hAAAA0000, 1, 7, 32'h5555FFFF, 0, 0,
                      {32'h5555FFFF, 32'h11111111, 32'h5555FFFF, 32'h5555FFFF}, 4'h0, 16'h0, 0);
        vecs[4]  = mk(16'h7777, 0, 0, 0, 0, 0, 0, 0, 0, {4{32'h5555FFFF}}, 4'h0, 16'h0, 1);
        vecs[5]  = mk(16'h7777, 0, 0, 0, 0, 0, 0, 0, 0, {4{32'h5555FFFF}}, 4'h0, 16'h0, 0);
        // L bypass on reg9
        vecs[6]  = mk(16'h9979, 1, 9, 32'h12345678, 0, 0, 0, 0, 0,
                      {32'h12345678, 32'h12345678, 32'h5555FFFF, 32'h12345678}, 4'h0, 16'h0, 0);
        vecs[7]  = mk(16'h0999, 0, 0, 0, 0, 0, 0, 0, 0,
                      {32'h0, 32'h12345678, 32'h12345678, 32'h12345678}, 4'h0, 16'h0, 0);
        // Scoreboard lifecycle on reg12
        vecs[8]  = mk(16'hC0CC, 0, 0, 0, 0, 0, 0, 1, 12, 128'h0, 4'h0, 16'h0, 0);
        vecs[9]  = mk(16'hCC0C, 0, 0, 0, 0, 0, 0, 0, 0, 128'h0, 4'b1101, 16'h1000, 0);
        vecs[10] = mk(16'hCC0C, 0, 0, 0, 0, 0, 0, 0, 0, 128'h0, 4'b1101, 16'h1000, 0);
        vecs[11] = mk(16'hCC0C, 0, 0, 0, 0, 0, 0, 0, 0, 128'h0, 4'b1101, 16'h1000, 0);
        vecs[12] = mk(16'hC5CC, 1, 12, 32'hC0DE000C, 0, 0, 0, 0, 0,
                      {32'hC0DE000C, 32'h0, 32'hC0DE000C, 32'hC0DE000C}, 4'h0, 16'h1000, 0);
        vecs[13] = mk(16'hCCCC, 0, 0, 0, 0, 0, 0, 0, 0, {4{32'hC0DE000C}}, 4'h0, 16'h0, 0);
        // Set/clear race: issue wins over returning load
        vecs[14] = mk(16'hCCCC, 1, 12, 32'h0BADF00D, 0, 0, 0, 1, 12, {4{32'h0BADF00D}}, 4'h0, 16'h0, 0);
        vecs[15] = mk(16'hCCCC, 0, 0, 0, 0, 0, 0, 0, 0, {4{32'h0BADF00D}}, 4'hF, 16'h1000, 0);
        // Re-issue while busy and an R write: busy unchanged
        vecs[16] = mk(16'hCCCC, 0, 0, 0, 1, 12, 32'h77777777, 1, 12, {4{32'h77777777}}, 4'hF, 16'h1000, 0);
        vecs[17] = mk(16'hCCCC, 0, 0, 0, 0, 0, 0, 0, 0, {4{32'h77777777}}, 4'hF, 16'h1000, 0);
        vecs[18] = mk(16'h6C6C, 1, 12, 32'h01020304, 0, 0, 0, 1, 6,
                      {32'h0, 32'h01020304, 32'h0, 32'h01020304}, 4'h0, 16'h1000, 0);
        vecs[19] = mk(16'h656C, 0, 0, 0, 1, 5, 32'hCAFE0005, 0, 0,
                      {32'h0, 32'hCAFE0005, 32'h0, 32'h01020304}, 4'b1010, 16'h0040, 0);

        SysReset = 1'b1;
        drive(vecs[0]);
        exp_q.push_back(vecs[0]);
        #7;
        check_outputs("reset");
        #1 SysReset = 1'b0;

        for (int k = 0; k < 20; k++) begin
            @(posedge SysClk);
            #1;
            drive(vecs[k]);
            exp_q.push_back(vecs[k]);
            @(negedge SysClk);
            check_outputs($sformatf("vec%0d", k));
        end

        // Reset pulse between edges while an R write to reg5 is in flight
        @(posedge SysClk);
        #1;
        begin
            vec_t v;
            v = mk(16'h5565, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0,
                   {32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF}, 4'b0010, 16'h0040, 0);
            drive(v);
            exp_q.push_back(v);
        end
        #1 check_outputs("pre_rst");
        #1 SysReset = 1'b1;
        exp_q.push_back(mk(16'h5565, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 128'h0, 4'h0, 16'h0, 0));
        #1 check_outputs("in_rst");
        #2;
        SysReset = 1'b0;
        drive(mk(16'h4365, 0, 0, 0, 0, 0, 0, 0, 0, 128'h0, 4'h0, 16'h0, 0));
        @(posedge SysClk);
        #1;
        exp_q.push_back(mk(16'h4365, 0, 0, 0, 0, 0, 0, 0, 0, 128'h0, 4'h0, 16'h0, 0));
        @(negedge SysClk);
        check_outputs("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
